pipe_ctrl: RTL and testbench

Parametrised pipeline stall/flush controller for the in-order core.
- Merges per-stage stall requests and a global halt into a per-stage hold mask and bubble-insert mask.
- Adds a flush state machine for branch/exception redirects. A flush is deferred while the redirecting stage is itself stalled.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the stage registers; every stage register reads its own bit of stall_out, bubble_out and flush_out.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/stall_mask_gen.sv | 43 ++++
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_PEND  = 2'd1,
        FS_FLUSH = 2'd2
    } fstate_e;

    localparam int unsigned MASK_W = 64;

    // Thermometer mask with bits 0..n set; callers size-cast to their width.
    function automatic logic [MASK_W-1:0] therm_mask(input int unsigned n);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (i <= n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/stall_mask_gen.sv
// Priority encoder turning per-stage stall requests plus halt into
// hold and bubble-insert masks.
module stall_mask_gen
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = 6
) (
    input  logic [NSTAGE-1:0] stall_req_i,
    input  logic              halt_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] bubble_o
);

    int unsigned h;
    logic        any_req;

    always_comb begin
        h       = 0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            if (stall_req_i[i]) begin
                h       = i;
                any_req = 1'b1;
            end
        end
    end

    // Everything younger than the oldest stalled stage holds; the stage
    // just older than it drains and must take a bubble.
    always_comb begin
        stall_o  = '0;
        bubble_o = '0;
        if (halt_i) begin
            stall_o = '1;
        end else if (any_req) begin
            stall_o = NSTAGE'(therm_mask(h));
            for (int unsigned i = 0; i < NSTAGE; i++) begin
                bubble_o[i] = (i == h + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: hold/bubble masks, deferred flush
// state machine and saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE    = 6,
    parameter int FLUSH_LEN = 1,
    parameter int CNT_W     = 32,
    parameter int SW        = $clog2(NSTAGE)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              halt_in,
    input  logic [NSTAGE-1:0] stall_req_in,
    input  logic              flush_req_in,
    input  logic [SW-1:0]     flush_stage_in,
    output logic              flush_ack_out,
    input  logic              cnt_clr_in,
    output logic [NSTAGE-1:0] stall_out,
    output logic [NSTAGE-1:0] bubble_out,
    output logic [NSTAGE-1:0] flush_out,
    output logic [CNT_W-1:0]  stall_cnt_out
);

    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam logic [FW-1:0] FLEN = FW'(FLUSH_LEN);
    localparam logic [FW-1:0] FONE = FW'(1);

    fstate_e          state_q, state_d;
    logic [SW-1:0]    fstage_q, fstage_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NSTAGE-1:0] raw_stall;
    logic [NSTAGE-1:0] raw_bubble;
    logic [NSTAGE-1:0] fmask;
    logic [NSTAGE-1:0] stall_fin;
    logic [NSTAGE-1:0] bubble_fin;
    logic              req_ok;
    logic              flushing;

    stall_mask_gen #(
        .NSTAGE (NSTAGE)
    ) u_mask (
        .stall_req_i (stall_req_in),
        .halt_i      (halt_in),
        .stall_o     (raw_stall),
        .bubble_o    (raw_bubble)
    );

    // The ack cycle precedes the clearing window, so the mask is held
    // off while ack_q is high.
    assign flushing = (state_q == FS_FLUSH) && !ack_q;

    always_comb begin
        fmask = '0;
        if (flushing && fstage_q != '0) begin
            fmask = NSTAGE'(therm_mask(32'(fstage_q) - 32'd1));
        end
    end

    assign stall_fin  = raw_stall & ~fmask;
    assign bubble_fin = raw_bubble & ~fmask;
    assign req_ok     = flush_req_in && (int'(flush_stage_in) < NSTAGE);

    always_comb begin
        state_d  = state_q;
        fstage_d = fstage_q;
        fcnt_d   = fcnt_q;
        ack_d    = 1'b0;
        unique case (state_q)
            FS_IDLE: begin
                if (req_ok) begin
                    fstage_d = flush_stage_in;
                    if (stall_fin[flush_stage_in]) begin
                        state_d = FS_PEND;
                    end else begin
                        state_d = FS_FLUSH;
                        fcnt_d  = FLEN;
                        ack_d   = 1'b1;
                    end
                end
            end
            FS_PEND: begin
                if (req_ok && flush_stage_in > fstage_q) begin
                    fstage_d = flush_stage_in;
                end
                if (!stall_fin[fstage_d]) begin
                    state_d = FS_FLUSH;
                    fcnt_d  = FLEN;
                    ack_d   = 1'b1;
                end
            end
            FS_FLUSH: begin
                if (req_ok && flush_stage_in > fstage_q) begin
                    fstage_d = flush_stage_in;
                    fcnt_d   = FLEN;
                    ack_d    = 1'b1;
                end else if (!ack_q) begin
                    if (fcnt_q == FONE) begin
                        state_d = FS_IDLE;
                    end else begin
                        fcnt_d = fcnt_q - FONE;
                    end
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_in) begin
            cnt_d = '0;
        end else if (stall_fin[0] && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= FS_IDLE;
            fstage_q <= '0;
            fcnt_q   <= '0;
            ack_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fstage_q <= fstage_d;
            fcnt_q   <= fcnt_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stall_out     = rst_in ? '0 : stall_fin;
    assign bubble_out    = rst_in ? '0 : bubble_fin;
    assign flush_out     = rst_in ? '0 : fmask;
    assign flush_ack_out = rst_in ? 1'b0 : ack_q;
    assign stall_cnt_out = rst_in ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int NS = 6;
    localparam int FL = 2;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          halt;
    logic [NS-1:0] sreq;
    logic          freq;
    logic [2:0]    fstg;
    logic          ack;
    logic          clr;
    logic [NS-1:0] stall;
    logic [NS-1:0] bubble;
    logic [NS-1:0] flush;
    logic [CW-1:0] cnt;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(
        .NSTAGE    (NS),
        .FLUSH_LEN (FL),
        .CNT_W     (CW)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .halt_in        (halt),
        .stall_req_in   (sreq),
        .flush_req_in   (freq),
        .flush_stage_in (fstg),
        .flush_ack_out  (ack),
        .cnt_clr_in     (clr),
        .stall_out      (stall),
        .bubble_out     (bubble),
        .flush_out      (flush),
        .stall_cnt_out  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; halt = 1; sreq = 6'b101010; freq = 1; fstg = 3; clr = 0;
        @(negedge clk);
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL rst_stall got %b want 000000", stall); end
        checks++; if (bubble !== 6'b0) begin errors++; $display("FAIL rst_bubble got %b want 000000", bubble); end
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL rst_flush got %b want 000000", flush); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", ack); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", cnt); end
        nxt();
        rst = 0; halt = 0; sreq = 0; freq = 0;
        @(negedge clk);
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL post_rst_cnt got %0d want 0", cnt); end
        checks++; if (flush !== 6'b0 || ack !== 1'b0) begin errors++; $display("FAIL post_rst_flush got %b/%b want 000000/0", flush, ack); end
        nxt();
    endtask

    task automatic test_stall_mask();
        sreq = 6'b001000;
        @(negedge clk);
        checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL mask_a_stall got %b want 001111", stall); end
        checks++; if (bubble !== 6'b010000) begin errors++; $display("FAIL mask_a_bubble got %b want 010000", bubble); end
        nxt();
        sreq = 6'b100010;
        @(negedge clk);
        checks++; if (stall !== 6'b111111) begin errors++; $display("FAIL mask_b_stall got %b want 111111", stall); end
        checks++; if (bubble !== 6'b000000) begin errors++; $display("FAIL mask_b_bubble got %b want 000000", bubble); end
        nxt();
        sreq = 6'b000001;
        @(negedge clk);
        checks++; if (stall !== 6'b000001 || bubble !== 6'b000010) begin errors++; $display("FAIL mask_c got %b/%b want 000001/000010", stall, bubble); end
        nxt();
        sreq = 6'b000000;
        @(negedge clk);
        checks++; if (stall !== 6'b0 || bubble !== 6'b0) begin errors++; $display("FAIL mask_none got %b/%b want 0/0", stall, bubble); end
        clr = 1;
        nxt();
        clr = 0;
    endtask

    task automatic test_immediate_flush();
        freq = 1; fstg = 3;
        @(negedge clk);
        checks++; if (ack !== 1'b0 || flush !== 6'b0) begin errors++; $display("FAIL imm_c0 got ack=%b flush=%b want 0/000000", ack, flush); end
        nxt();
        freq = 0;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL imm_ack got %b want 1", ack); end
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL imm_ackcyc_flush got %b want 000000", flush); end
        nxt();
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++; if (flush !== 6'b000111 || ack !== 1'b0) begin errors++; $display("FAIL imm_flush%0d got %b ack=%b want 000111 ack=0", i, flush, ack); end
            nxt();
        end
        @(negedge clk);
        checks++; if (flush !== 6'b0 || ack !== 1'b0) begin errors++; $display("FAIL imm_end got %b ack=%b want 000000 ack=0", flush, ack); end
        nxt();
    endtask

    task automatic test_deferred_flush();
        sreq = 6'b010000; freq = 1; fstg = 2;
        @(negedge clk);
        checks++; if (stall !== 6'b011111 || bubble !== 6'b100000) begin errors++; $display("FAIL def_mask got %b/%b want 011111/100000", stall, bubble); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL def_c0_ack got %b want 0", ack); end
        nxt();
        freq = 0;
        for (int i = 1; i < 4; i++) begin
            if (i == 3) sreq = 6'b0;
            @(negedge clk);
            checks++; if (ack !== 1'b0 || flush !== 6'b0) begin errors++; $display("FAIL def_wait%0d got ack=%b flush=%b want 0/000000", i, ack, flush); end
            nxt();
        end
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL def_ack got %b want 1", ack); end
        nxt();
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++; if (flush !== 6'b000011) begin errors++; $display("FAIL def_flush%0d got %b want 000011", i, flush); end
            nxt();
        end
        @(negedge clk);
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL def_end got %b want 000000", flush); end
        clr = 1;
        nxt();
        clr = 0;
    endtask

    task automatic test_override_restart();
        freq = 1; fstg = 3;
        nxt();
        freq = 0;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ovr_ack1 got %b want 1", ack); end
        nxt();
        sreq = 6'b000100;
        @(negedge clk);
        checks++; if (flush !== 6'b000111) begin errors++; $display("FAIL ovr_flush got %b want 000111", flush); end
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL ovr_stall got %b want 000000", stall); end
        checks++; if (bubble !== 6'b001000) begin errors++; $display("FAIL ovr_bubble got %b want 001000", bubble); end
        nxt();
        sreq = 0; halt = 1; freq = 1; fstg = 4;
        @(negedge clk);
        checks++; if (stall !== 6'b111000 || bubble !== 6'b0) begin errors++; $display("FAIL ovr_halt got %b/%b want 111000/000000", stall, bubble); end
        nxt();
        halt = 0; freq = 0;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ovr_ack2 got %b want 1", ack); end
        nxt();
        freq = 1; fstg = 1;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++; if (flush !== 6'b001111 || ack !== 1'b0) begin errors++; $display("FAIL ovr_restart%0d got %b ack=%b want 001111 ack=0", i, flush, ack); end
            nxt();
            freq = 0;
        end
        @(negedge clk);
        checks++; if (flush !== 6'b0 || ack !== 1'b0) begin errors++; $display("FAIL ovr_end got %b ack=%b want 000000 ack=0", flush, ack); end
        nxt();
    endtask

    task automatic test_halt_counter();
        clr = 1;
        nxt();
        clr = 0; halt = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (stall !== 6'b111111 || bubble !== 6'b0) begin errors++; $display("FAIL halt%0d got %b/%b want 111111/000000", i, stall, bubble); end
            nxt();
        end
        halt = 0;
        @(negedge clk);
        checks++; if (cnt !== 4'd5) begin errors++; $display("FAIL cnt5 got %0d want 5", cnt); end
        nxt();
        halt = 1; clr = 1;
        nxt();
        halt = 0; clr = 0;
        @(negedge clk);
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL cnt_clr got %0d want 0", cnt); end
        nxt();
        halt = 1;
        for (int i = 0; i < 20; i++) nxt();
        halt = 0;
        @(negedge clk);
        checks++; if (cnt !== 4'd15) begin errors++; $display("FAIL cnt_sat got %0d want 15", cnt); end
        clr = 1;
        nxt();
        clr = 0;
    endtask

    task automatic test_reset_mid_flush();
        halt = 1;
        nxt();
        nxt();
        halt = 0; freq = 1; fstg = 5;
        nxt();
        freq = 0;
        @(negedge clk);
        checks++; if (ack !== 1'b1 || cnt !== 4'd2) begin errors++; $display("FAIL rmf_pre got ack=%b cnt=%0d want 1/2", ack, cnt); end
        nxt();
        @(negedge clk);
        checks++; if (flush !== 6'b011111) begin errors++; $display("FAIL rmf_flush got %b want 011111", flush); end
        nxt();
        rst = 1; halt = 1; sreq = 6'b110011;
        @(negedge clk);
        checks++; if (stall !== 6'b0 || bubble !== 6'b0 || flush !== 6'b0) begin errors++; $display("FAIL rmf_rst_out got %b/%b/%b want 0/0/0", stall, bubble, flush); end
        checks++; if (cnt !== 4'd0 || ack !== 1'b0) begin errors++; $display("FAIL rmf_rst_cnt got %0d ack=%b want 0/0", cnt, ack); end
        nxt();
        rst = 0; halt = 0; sreq = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (flush !== 6'b0 || ack !== 1'b0 || cnt !== 4'd0) begin errors++; $display("FAIL rmf_after%0d got %b ack=%b cnt=%0d want 0/0/0", i, flush, ack, cnt); end
            nxt();
        end
        sreq = 6'b100000; freq = 1; fstg = 2;
        nxt();
        freq = 0; rst = 1;
        nxt();
        rst = 0; sreq = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ack !== 1'b0 || flush !== 6'b0) begin errors++; $display("FAIL rmp_after%0d got ack=%b flush=%b want 0/000000", i, ack, flush); end
            nxt();
        end
    endtask

    task automatic test_random();
        int pend, fst, left, cnt_m, h, eff, nk;
        bit ackn, acc;
        logic [NS-1:0] rs, rb, fm, es, eb;
        rst = 1; halt = 0; sreq = 0; freq = 0; clr = 0;
        nxt();
        rst = 0;
        pend = -1; fst = 0; left = 0; ackn = 0; cnt_m = 0;
        for (int c = 0; c < 2000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            halt = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NS; i++) sreq[i] = ($urandom_range(0, 7) == 0);
            freq = ($urandom_range(0, 3) == 0);
            fstg = 3'($urandom_range(0, NS - 1));
            clr  = ($urandom_range(0, 49) == 0);
            h = -1;
            for (int i = 0; i < NS; i++) if (sreq[i]) h = i;
            rs = '0; rb = '0; fm = '0;
            if (halt) rs = '1;
            else if (h >= 0) begin
                for (int i = 0; i <= h; i++) rs[i] = 1'b1;
                if (h + 1 < NS) rb[h + 1] = 1'b1;
            end
            if (left > 0 && !ackn) for (int i = 0; i < fst; i++) fm[i] = 1'b1;
            es = rs & ~fm;
            eb = rb & ~fm;
            @(negedge clk);
            if (rst) begin
                checks++; if (stall !== 6'b0 || bubble !== 6'b0 || flush !== 6'b0 || ack !== 1'b0 || cnt !== 4'd0) begin errors++; $display("FAIL rnd_rst cyc=%0d got %b/%b/%b/%b/%0d want all 0", c, stall, bubble, flush, ack, cnt); end
            end else begin
                checks++; if (stall !== es) begin errors++; $display("FAIL rnd_stall cyc=%0d got %b want %b", c, stall, es); end
                checks++; if (bubble !== eb) begin errors++; $display("FAIL rnd_bubble cyc=%0d got %b want %b", c, bubble, eb); end
                checks++; if (flush !== fm) begin errors++; $display("FAIL rnd_flush cyc=%0d got %b want %b", c, flush, fm); end
                checks++; if (ack !== ackn) begin errors++; $display("FAIL rnd_ack cyc=%0d got %b want %b", c, ack, ackn); end
                checks++; if (cnt !== 4'(cnt_m)) begin errors++; $display("FAIL rnd_cnt cyc=%0d got %0d want %0d", c, cnt, cnt_m); end
            end
            if (rst) begin
                pend = -1; left = 0; ackn = 0; cnt_m = 0;
            end else begin
                acc = 0; nk = 0;
                if (left > 0) begin
                    if (freq && int'(fstg) > fst) begin acc = 1; nk = int'(fstg); end
                end else if (pend >= 0) begin
                    eff = (freq && int'(fstg) > pend) ? int'(fstg) : pend;
                    if (!es[eff]) begin acc = 1; nk = eff; pend = -1; end
                    else pend = eff;
                end else if (freq) begin
                    if (es[fstg]) pend = int'(fstg);
                    else begin acc = 1; nk = int'(fstg); end
                end
                if (clr) cnt_m = 0;
                else if (es[0] && cnt_m < 15) cnt_m++;
                if (acc) begin
                    fst = nk; left = FL; ackn = 1;
                end else begin
                    if (left > 0 && !ackn) left--;
                    ackn = 0;
                end
            end
            nxt();
        end
        rst = 0; halt = 0; sreq = 0; freq = 0; clr = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; halt = 0; sreq = 0; freq = 0; fstg = 0; clr = 0;
        test_reset();
        test_stall_mask();
        test_immediate_flush();
        test_deferred_flush();
        test_override_restart();
        test_halt_counter();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
